// File: rtl/select_logic.sv
// Select half of the issue scheduler: per-FU oldest-ready grant with an age matrix,
// registered one-cycle grant/free/clear pulses and a running count of valid rows.
module select_logic #(
  parameter int NUM_ROWS = 8,
  parameter int NUM_COLS = 8,
  parameter int NUM_FUS  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  alloc_en,
  input  logic [$clog2(NUM_ROWS)-1:0]           alloc_row,
  input  logic [$clog2(NUM_FUS)-1:0]            alloc_fu,
  input  logic [NUM_ROWS-1:0]                   request_vector,
  input  logic [NUM_FUS-1:0]                    fu_ready,
  output logic [NUM_FUS-1:0]                    grant_valid,
  output logic [NUM_FUS*$clog2(NUM_ROWS)-1:0]   grant_row,
  output logic [NUM_ROWS-1:0]                   free_mask,
  output logic                                  clear_en,
  output logic [NUM_COLS*NUM_FUS-1:0]           clear_lines,
  output logic [$clog2(NUM_ROWS):0]             occupancy
);

  localparam int RW = $clog2(NUM_ROWS);
  localparam int FW = $clog2(NUM_FUS);
  localparam int OW = RW + 1;

  generate
    if (NUM_COLS != NUM_ROWS) begin : g_bad_cols
      $error("select_logic: NUM_COLS must equal NUM_ROWS");
    end
    if (NUM_ROWS < 2 || (NUM_ROWS & (NUM_ROWS - 1)) != 0) begin : g_bad_rows
      $error("select_logic: NUM_ROWS must be a power of two >= 2");
    end
    if (NUM_FUS < 2 || (NUM_FUS & (NUM_FUS - 1)) != 0) begin : g_bad_fus
      $error("select_logic: NUM_FUS must be a power of two >= 2");
    end
  endgenerate

  // Per-row state; older[i][j] set means row j is older than row i.
  logic [NUM_ROWS-1:0] valid;
  logic [FW-1:0]       fu_tag [NUM_ROWS];
  logic [NUM_ROWS-1:0] older  [NUM_ROWS];

  logic                          alloc_do;
  logic [NUM_ROWS-1:0]           alloc_onehot;
  logic [NUM_ROWS-1:0]           eligible;
  logic [NUM_ROWS-1:0]           cand [NUM_FUS];
  logic [NUM_FUS-1:0]            win_any;
  logic [NUM_FUS*RW-1:0]         win_row;
  logic [NUM_ROWS-1:0]           winners;
  logic [NUM_COLS*NUM_FUS-1:0]   clear_next;
  logic [NUM_ROWS-1:0]           valid_after_free;
  logic [NUM_ROWS-1:0]           valid_next_excl;
  logic [NUM_ROWS-1:0]           valid_next;
  logic [NUM_ROWS-1:0]           older_next [NUM_ROWS];
  logic [OW-1:0]                 occ_next;

  assign alloc_do = alloc_en & ~flush;

  always_comb begin
    alloc_onehot = '0;
    alloc_onehot[alloc_row] = 1'b1;
  end

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_ROWS; i++) begin
      eligible[i] = valid[i] & request_vector[i] & fu_ready[fu_tag[i]];
    end
  end

  // A candidate wins when no other candidate of the same FU is older than it.
  always_comb begin
    win_any    = '0;
    win_row    = '0;
    winners    = '0;
    clear_next = '0;
    for (int unsigned f = 0; f < NUM_FUS; f++) begin
      cand[f] = '0;
      for (int unsigned i = 0; i < NUM_ROWS; i++) begin
        cand[f][i] = eligible[i] & (fu_tag[i] == FW'(f));
      end
    end
    for (int unsigned f = 0; f < NUM_FUS; f++) begin
      for (int unsigned i = 0; i < NUM_ROWS; i++) begin
        if (cand[f][i] && ((older[i] & cand[f]) == '0)) begin
          win_any[f]                 = 1'b1;
          win_row[f*RW +: RW]        = RW'(i);
          winners[i]                 = 1'b1;
          clear_next[f*NUM_COLS + i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_after_free = valid & ~winners;
    valid_next_excl  = valid_after_free & ~alloc_onehot;
    if (flush) begin
      valid_next = '0;
    end else if (alloc_do) begin
      valid_next = valid_after_free | alloc_onehot;
    end else begin
      valid_next = valid_after_free;
    end
  end

  // Freed rows drop all age links; a new row is youngest relative to the survivors.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ROWS; i++) begin
      older_next[i] = older[i];
      for (int unsigned j = 0; j < NUM_ROWS; j++) begin
        if (winners[i] || winners[j]) begin
          older_next[i][j] = 1'b0;
        end
        if (alloc_do) begin
          if (RW'(i) == alloc_row) begin
            older_next[i][j] = valid_next_excl[j];
          end else if (RW'(j) == alloc_row) begin
            older_next[i][j] = 1'b0;
          end
        end
      end
      if (flush) begin
        older_next[i] = '0;
      end
    end
  end

  always_comb begin
    occ_next = '0;
    for (int unsigned i = 0; i < NUM_ROWS; i++) begin
      occ_next = occ_next + OW'(valid_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid       <= '0;
      occupancy   <= '0;
      grant_valid <= '0;
      grant_row   <= '0;
      free_mask   <= '0;
      clear_en    <= 1'b0;
      clear_lines <= '0;
      for (int unsigned i = 0; i < NUM_ROWS; i++) begin
        fu_tag[i] <= '0;
        older[i]  <= '0;
      end
    end else begin
      valid     <= valid_next;
      occupancy <= occ_next;
      for (int unsigned i = 0; i < NUM_ROWS; i++) begin
        older[i] <= older_next[i];
      end
      if (alloc_do) begin
        fu_tag[alloc_row] <= alloc_fu;
      end
      if (flush) begin
        grant_valid <= '0;
        grant_row   <= '0;
        free_mask   <= '0;
        clear_en    <= 1'b0;
        clear_lines <= '0;
      end else begin
        grant_valid <= win_any;
        grant_row   <= win_row;
        free_mask   <= winners;
        clear_en    <= |win_any;
        clear_lines <= clear_next;
      end
    end
  end

  a_alloc_to_free_row: assert property (@(posedge clk) disable iff (!rst)
    (alloc_en && !flush) |-> !valid[alloc_row]);

  a_alloc_not_full: assert property (@(posedge clk) disable iff (!rst)
    (alloc_en && !flush) |-> (occupancy != OW'(NUM_ROWS)));

endmodule

// File: tb/tb_select_logic.sv
// Bench for select_logic: directed scenarios plus random traffic against a
// timestamp-based oldest-first reference model.
module tb_select_logic;

  localparam int NR = 8;
  localparam int NF = 4;
  localparam int RW = 3;
  localparam int FW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              flush;
  logic              alloc_en;
  logic [RW-1:0]     alloc_row;
  logic [FW-1:0]     alloc_fu;
  logic [NR-1:0]     request_vector;
  logic [NF-1:0]     fu_ready;
  logic [NF-1:0]     grant_valid;
  logic [NF*RW-1:0]  grant_row;
  logic [NR-1:0]     free_mask;
  logic              clear_en;
  logic [NR*NF-1:0]  clear_lines;
  logic [RW:0]       occupancy;

  select_logic #(.NUM_ROWS(NR), .NUM_COLS(NR), .NUM_FUS(NF)) dut (
    .clk(clk), .rst(rst), .flush(flush), .alloc_en(alloc_en),
    .alloc_row(alloc_row), .alloc_fu(alloc_fu), .request_vector(request_vector),
    .fu_ready(fu_ready), .grant_valid(grant_valid), .grant_row(grant_row),
    .free_mask(free_mask), .clear_en(clear_en), .clear_lines(clear_lines),
    .occupancy(occupancy)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: oldest row is the one with the smallest allocation stamp.
  bit              m_valid [NR];
  int unsigned     m_fu    [NR];
  longint unsigned m_stamp [NR];
  longint unsigned stamp_ctr = 0;

  logic [NF-1:0]    e_gv;
  logic [NF*RW-1:0] e_gr;
  logic [NR-1:0]    e_fm;
  logic [NR*NF-1:0] e_cl;
  logic [RW:0]      e_occ;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int unsigned model_occ();
    int unsigned c = 0;
    for (int unsigned i = 0; i < NR; i++) c += m_valid[i] ? 1 : 0;
    return c;
  endfunction

  task automatic step();
    int unsigned best;
    bit          found;
    e_gv = '0; e_gr = '0; e_fm = '0; e_cl = '0;
    if (!rst) begin
      for (int unsigned i = 0; i < NR; i++) begin
        m_valid[i] = 1'b0; m_fu[i] = 0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < NR; i++) m_valid[i] = 1'b0;
    end else begin
      for (int unsigned f = 0; f < NF; f++) begin
        found = 1'b0; best = 0;
        for (int unsigned i = 0; i < NR; i++) begin
          if (m_valid[i] && request_vector[i] && fu_ready[m_fu[i]] && m_fu[i] == f) begin
            if (!found || m_stamp[i] < m_stamp[best]) begin
              best = i; found = 1'b1;
            end
          end
        end
        if (found) begin
          e_gv[f] = 1'b1;
          e_gr[f*RW +: RW] = best[RW-1:0];
          e_fm[best] = 1'b1;
          e_cl[f*NR + best] = 1'b1;
        end
      end
      for (int unsigned i = 0; i < NR; i++) if (e_fm[i]) m_valid[i] = 1'b0;
      if (alloc_en) begin
        m_valid[alloc_row] = 1'b1;
        m_fu[alloc_row]    = alloc_fu;
        m_stamp[alloc_row] = stamp_ctr;
        stamp_ctr++;
      end
    end
    e_occ = (RW+1)'(model_occ());
    @(posedge clk);
    #1;
    check("grant_valid", 64'(grant_valid), 64'(e_gv));
    check("grant_row",   64'(grant_row),   64'(e_gr));
    check("free_mask",   64'(free_mask),   64'(e_fm));
    check("clear_en",    64'(clear_en),    64'(|e_gv));
    check("clear_lines", 64'(clear_lines), 64'(e_cl));
    check("occupancy",   64'(occupancy),   64'(e_occ));
  endtask

  task automatic drive(input bit a_en, input int unsigned a_row, input int unsigned a_fu,
                       input logic [NR-1:0] req, input logic [NF-1:0] rdy, input bit fl);
    alloc_en       = a_en;
    alloc_row      = a_row[RW-1:0];
    alloc_fu       = a_fu[FW-1:0];
    request_vector = req;
    fu_ready       = rdy;
    flush          = fl;
    step();
  endtask

  initial begin
    int unsigned free_rows [$];
    int unsigned pick;
    rst = 1'b0; flush = 1'b0; alloc_en = 1'b0; alloc_row = '0; alloc_fu = '0;
    request_vector = '0; fu_ready = '0;

    // Reset and idle
    drive(0, 0, 0, 8'h00, 4'hF, 0);
    drive(0, 0, 0, 8'hFF, 4'hF, 0);
    check("reset_occ", 64'(occupancy), 64'd0);
    rst = 1'b1;
    drive(0, 0, 0, 8'h00, 4'hF, 0);

    // Rows 3,5 on FU0, oldest first
    drive(1, 3, 0, 8'h00, 4'hF, 0);
    drive(1, 5, 0, 8'h00, 4'hF, 0);
    drive(0, 0, 0, 8'h28, 4'hF, 0);
    check("tp1_gv",   64'(grant_valid), 64'h1);
    check("tp1_row3", 64'(grant_row[2:0]), 64'd3);
    check("tp1_free", 64'(free_mask), 64'h08);
    check("tp1_clr",  64'(clear_lines), 64'h8);
    drive(0, 0, 0, 8'h28, 4'hF, 0);
    check("tp1_row5", 64'(grant_row[2:0]), 64'd5);
    drive(0, 0, 0, 8'h28, 4'hF, 0);
    check("tp1_idle", 64'(grant_valid), 64'h0);

    // Rows 7,2,4 on FU1 issue in allocation order
    drive(1, 7, 1, 8'h00, 4'hF, 0);
    drive(1, 2, 1, 8'h00, 4'hF, 0);
    drive(1, 4, 1, 8'h00, 4'hF, 0);
    check("tp2_occ3", 64'(occupancy), 64'd3);
    drive(0, 0, 0, 8'h94, 4'hF, 0);
    check("tp2_row7", 64'(grant_row[5:3]), 64'd7);
    check("tp2_occ2", 64'(occupancy), 64'd2);
    drive(0, 0, 0, 8'h94, 4'hF, 0);
    check("tp2_row2", 64'(grant_row[5:3]), 64'd2);
    drive(0, 0, 0, 8'h94, 4'hF, 0);
    check("tp2_row4", 64'(grant_row[5:3]), 64'd4);
    check("tp2_occ0", 64'(occupancy), 64'd0);

    // One row per FU, all granted together
    for (int unsigned r = 0; r < 4; r++) drive(1, r, r, 8'h00, 4'hF, 0);
    drive(0, 0, 0, 8'h0F, 4'hF, 0);
    check("tp3_gv",  64'(grant_valid), 64'hF);
    check("tp3_fm",  64'(free_mask), 64'h0F);
    check("tp3_clr", 64'(clear_lines), 64'h0804_0201);
    check("tp3_occ", 64'(occupancy), 64'd0);

    // FU2 not ready holds row 6
    drive(1, 6, 2, 8'h00, 4'hF, 0);
    for (int unsigned k = 0; k < 3; k++) drive(0, 0, 0, 8'h40, 4'hB, 0);
    check("tp4_hold", 64'(grant_valid), 64'h0);
    drive(0, 0, 0, 8'h40, 4'hF, 0);
    check("tp4_gv",  64'(grant_valid), 64'h4);
    check("tp4_row", 64'(grant_row[8:6]), 64'd6);
    drive(0, 0, 0, 8'h40, 4'hF, 0);
    check("tp4_nodbl", 64'(grant_valid), 64'h0);

    // Fill, then flush with alloc_en asserted
    for (int unsigned r = 0; r < NR; r++) drive(1, r, r % NF, 8'h00, 4'hF, 0);
    check("tp5_full", 64'(occupancy), 64'd8);
    drive(1, 0, 0, 8'hFF, 4'hF, 1);
    check("tp5_occ", 64'(occupancy), 64'd0);
    check("tp5_gv",  64'(grant_valid), 64'h0);
    drive(0, 0, 0, 8'hFF, 4'hF, 0);
    check("tp5_after", 64'(grant_valid), 64'h0);

    // Alloc and grant in the same cycle
    drive(1, 4, 0, 8'h00, 4'hF, 0);
    drive(1, 1, 0, 8'h10, 4'hF, 0);
    check("tp6_row4", 64'(grant_row[2:0]), 64'd4);
    check("tp6_occ",  64'(occupancy), 64'd1);
    drive(0, 0, 0, 8'h02, 4'hF, 0);
    check("tp6_row1", 64'(grant_row[2:0]), 64'd1);
    check("tp6_occ0", 64'(occupancy), 64'd0);

    // Random traffic, occasional flush and reset
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 199) != 0);
      free_rows.delete();
      for (int unsigned i = 0; i < NR; i++) if (!m_valid[i]) free_rows.push_back(i);
      if (free_rows.size() != 0 && $urandom_range(0, 2) != 0) begin
        pick = free_rows[$urandom_range(0, free_rows.size() - 1)];
        drive(1, pick, $urandom_range(0, NF - 1), NR'($urandom), NF'($urandom),
              $urandom_range(0, 49) == 0);
      end else begin
        drive(0, $urandom_range(0, NR - 1), $urandom_range(0, NF - 1), NR'($urandom),
              NF'($urandom), $urandom_range(0, 49) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
